// File: rtl/branch_predictor_bht_pkg.sv
// Purpose: shared counter encodings and saturating helpers for the branch history table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package branch_predictor_bht_pkg;

    localparam logic [1:0] BHT_STRONG_NT   = 2'b00;
    localparam logic [1:0] BHT_WEAK_NT     = 2'b01;
    localparam logic [1:0] BHT_WEAK_T      = 2'b10;
    localparam logic [1:0] BHT_STRONG_T    = 2'b11;
    localparam logic [1:0] BHT_RESET_STATE = BHT_WEAK_NT;

    // Next 2-bit counter state: step toward the resolved outcome, pinned at the ends.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != BHT_STRONG_T) nxt = ctr + 2'd1;
        end else begin
            if (ctr != BHT_STRONG_NT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // 32-bit increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_counter_table.sv
// Purpose: flop-based array of 2-bit saturating counters, one comb read port, one training write port.
// Latency: read is combinational from registered state; a write is visible the cycle after it is taken.
// Backpressure: none; a write is accepted every cycle i_wr_en is high.
// Ports: clk/rst_n; i_rd_idx -> o_rd_ctr; i_wr_en, i_wr_idx, i_wr_taken train one entry.
module bht_counter_table
    import branch_predictor_bht_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [1:0]         o_rd_ctr,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic               i_wr_taken
);

    // Flops rather than RAM: every entry must return to weak-NT on async reset.
    logic [1:0] r_ctr [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= BHT_RESET_STATE;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= bht_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the pre-update counter.
    assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_predictor_bht.sv
// Purpose: 2-bit-counter branch predictor with target adder and saturating perf counters.
// Latency: prediction/target zero-cycle combinational; training and perf counts land at the next edge.
// Backpressure: none; lookups and updates are accepted every cycle.
// Ports: i_lkp_* -> o_predicted/o_pred_target; i_upd_* trains the table; o_perf_* count resolutions.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_W     = 6,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lkp_valid,
    input  logic [ADDR_W-1:0] i_lkp_pc,
    input  logic [ADDR_W-1:0] i_lkp_offset,
    output logic              o_predicted,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic              i_upd_mispredict,
    output logic [31:0]       o_perf_branches,
    output logic [31:0]       o_perf_mispred
);

    logic [INDEX_W-1:0] w_lkp_idx;
    logic [INDEX_W-1:0] w_upd_idx;
    logic [1:0]         w_lkp_ctr;
    logic               w_unused_pc_bits;
    logic [31:0]        r_perf_branches;
    logic [31:0]        r_perf_mispred;

    // Word-aligned index; byte offset and upper PC bits alias by design (no tags).
    assign w_lkp_idx = i_lkp_pc[INDEX_W+1:2];
    assign w_upd_idx = i_upd_pc[INDEX_W+1:2];
    assign w_unused_pc_bits = ^{i_lkp_pc[ADDR_W-1:INDEX_W+2], i_lkp_pc[1:0],
                                i_upd_pc[ADDR_W-1:INDEX_W+2], i_upd_pc[1:0]};

    bht_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .INDEX_W (INDEX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_lkp_idx),
        .o_rd_ctr   (w_lkp_ctr),
        .i_wr_en    (i_upd_valid),
        .i_wr_idx   (w_upd_idx),
        .i_wr_taken (i_upd_taken)
    );

    // MSB of the counter is the taken/not-taken decision.
    assign o_predicted   = i_lkp_valid & w_lkp_ctr[1];
    assign o_pred_target = i_lkp_pc + i_lkp_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches <= '0;
            r_perf_mispred  <= '0;
        end else if (i_upd_valid) begin
            r_perf_branches <= sat_inc32(r_perf_branches);
            if (i_upd_mispredict) begin
                r_perf_mispred <= sat_inc32(r_perf_mispred);
            end
        end
    end

    assign o_perf_branches = r_perf_branches;
    assign o_perf_mispred  = r_perf_mispred;

endmodule
